// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss/fill path.
// The fill controller and the cache tag/data arrays both use these constants,
// so the block geometry is defined in one place.
package cache_fill_fsm_pkg;

  // Block geometry: 8 words of 2 bytes, giving 16-byte aligned blocks.
  localparam int CF_WORDS_PER_BLOCK = 8;
  localparam int CF_WORD_BYTES      = 2;
  localparam int CF_ADDR_W          = 16;
  localparam int CF_BLOCK_BYTES     = CF_WORDS_PER_BLOCK * CF_WORD_BYTES;
  localparam int CF_BLOCK_OFFSET_W  = $clog2(CF_BLOCK_BYTES);
  localparam int CF_WORD_IDX_W      = $clog2(CF_WORDS_PER_BLOCK);

  // Fill controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with enable, synchronous clear and asynchronous reset.
// Used by the fill controller for the request and the return counts.
module cache_fill_fsm_fill_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_ZERO;
    end else if (clr) begin
      count <= CNT_ZERO;
    end else if (en) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller.
// On a miss it fetches one aligned block from pipelined main memory: requests
// are streamed back-to-back from the block base, returned words are written
// into the data array in request order, then the tag is committed for one
// cycle and the stall is released.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = CF_WORDS_PER_BLOCK,
  parameter int ADDR_W          = CF_ADDR_W,
  parameter int WORD_BYTES      = CF_WORD_BYTES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data,
  output logic                               fsm_busy,
  output logic                               mem_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               write_tag_array,
  output logic                               fill_done
);

  localparam int IDX_W       = $clog2(WORDS_PER_BLOCK);
  // One extra bit so the request count can reach WORDS_PER_BLOCK.
  localparam int CNT_W       = IDX_W + 1;
  localparam int BLOCK_BYTES = WORDS_PER_BLOCK * WORD_BYTES;

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLOCK_BYTES - 1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};

  fill_state_e       state_r;
  logic [ADDR_W-1:0] base_r;
  logic              fsm_busy_r;

  logic [CNT_W-1:0]  req_cnt_s;
  logic [CNT_W-1:0]  ret_cnt_s;
  logic              cnt_clr_s;
  logic              req_en_s;
  logic              ret_en_s;
  logic              last_word_s;

  // Returned data goes straight to the data array; the controller only
  // qualifies the write, it never looks at the word itself.
  logic              data_unused_s;
  assign data_unused_s = ^memory_data;

  // Counter control: clear on miss acceptance, request while the block is not
  // fully requested, accept a return only when a request is outstanding.
  always_comb begin
    cnt_clr_s = 1'b0;
    req_en_s  = 1'b0;
    ret_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_clr_s = miss_detected;
      end
      ST_FILL: begin
        req_en_s = (req_cnt_s < CNT_FULL);
        ret_en_s = memory_data_valid && (ret_cnt_s < req_cnt_s);
      end
      ST_COMMIT: begin
        cnt_clr_s = 1'b0;
      end
      default: begin
        cnt_clr_s = 1'b0;
      end
    endcase
  end

  assign last_word_s = ret_en_s && (ret_cnt_s == CNT_LAST);

  cache_fill_fsm_fill_counter #(
    .WIDTH (CNT_W)
  ) u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (req_en_s),
    .count (req_cnt_s)
  );

  cache_fill_fsm_fill_counter #(
    .WIDTH (CNT_W)
  ) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (ret_en_s),
    .count (ret_cnt_s)
  );

  // Fill sequencing: latch the aligned block base on a miss, leave FILL on
  // the last accepted word, spend exactly one cycle in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      base_r     <= ADDR_ZERO;
      fsm_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_detected) begin
            state_r    <= ST_FILL;
            base_r     <= miss_address & ALIGN_MASK;
            fsm_busy_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            base_r     <= base_r;
            fsm_busy_r <= 1'b0;
          end
        end
        ST_FILL: begin
          if (last_word_s) begin
            state_r <= ST_COMMIT;
          end else begin
            state_r <= ST_FILL;
          end
          base_r     <= base_r;
          fsm_busy_r <= 1'b1;
        end
        ST_COMMIT: begin
          state_r    <= ST_IDLE;
          base_r     <= base_r;
          fsm_busy_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          base_r     <= ADDR_ZERO;
          fsm_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Output decode from state and counters; the address is only driven while
  // a request is being issued so it reads 0 in IDLE and after reset.
  always_comb begin
    mem_read_en      = req_en_s;
    write_data_array = ret_en_s;
    fsm_busy         = fsm_busy_r;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    fill_word        = IDX_ZERO;
    if (req_en_s) begin
      memory_address = base_r + (ADDR_W'(req_cnt_s) * STRIDE);
    end else begin
      memory_address = ADDR_ZERO;
    end
    case (state_r)
      ST_IDLE: begin
        fill_word = IDX_ZERO;
      end
      ST_FILL: begin
        fill_word = ret_cnt_s[IDX_W-1:0];
      end
      ST_COMMIT: begin
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
      end
      default: begin
        fill_word = IDX_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomised scoreboard bench for cache_fill_fsm with a pipelined memory model.
module tb_cache_fill_fsm;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic        write_tag_array;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int due; logic [15:0] addr; } ret_t;
  typedef struct { logic [15:0] addr; int at; } req_t;
  typedef struct { logic [2:0] idx; logic [15:0] data; } wr_t;

  ret_t ret_q[$];
  req_t exp_req_q[$];
  wr_t  exp_wr_q[$];

  int gap_mode   = 0;
  int extra_max  = 0;
  bit in_fill_m  = 1'b0;
  int done_due   = -1;
  int accept_cyc = 0;
  int words_seen = 0;
  bit lat_chk    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hA000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Memory request capture: each request returns L (+ optional jitter) cycles later, in order.
  initial begin
    int due;
    int gap;
    forever begin
      @(negedge clk);
      if (!rst && mem_read_en) begin
        gap = (gap_mode != 0) ? 2 : 1;
        due = cyc + L + ((extra_max > 0) ? int'($urandom_range(extra_max, 0)) : 0);
        if (ret_q.size() > 0 && due < ret_q[$].due + gap) due = ret_q[$].due + gap;
        ret_q.push_back('{due, memory_address});
      end
    end
  end

  // Memory return driver; spurious valids only when nothing is outstanding.
  initial begin
    ret_t r;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        memory_data_valid = 1'b1;
        memory_data       = mem_word(r.addr);
      end else if (ret_q.size() == 0 && $urandom_range(1, 0) == 1) begin
        memory_data_valid = 1'b1;
        memory_data       = 16'($urandom);
      end else begin
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
      end
    end
  end

  // Monitor and reference model: expected requests/writes are queued when a miss is accepted.
  initial begin
    bit          exp_done;
    req_t        rq;
    wr_t         wr;
    logic [15:0] base;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_busy", 32'(fsm_busy), 32'd0);
        check("rst_read_en", 32'(mem_read_en), 32'd0);
        check("rst_addr", 32'(memory_address), 32'd0);
        check("rst_write", 32'(write_data_array), 32'd0);
        check("rst_tag", 32'(write_tag_array), 32'd0);
        check("rst_done", 32'(fill_done), 32'd0);
        exp_req_q.delete();
        exp_wr_q.delete();
        in_fill_m = 1'b0;
        done_due  = -1;
      end else begin
        exp_done = (done_due == cyc);
        check("fsm_busy", 32'(fsm_busy), 32'(in_fill_m));
        check("fill_done", 32'(fill_done), 32'(exp_done));
        check("write_tag_array", 32'(write_tag_array), 32'(exp_done));
        if (mem_read_en) begin
          if (exp_req_q.size() == 0) begin
            check("unexpected_request", 32'(memory_address), 32'hFFFF_FFFF);
          end else begin
            rq = exp_req_q.pop_front();
            check("req_addr", 32'(memory_address), 32'(rq.addr));
            check("req_cycle", 32'(cyc), 32'(rq.at));
          end
        end
        if (write_data_array) begin
          if (exp_wr_q.size() == 0) begin
            check("unexpected_write", 32'(fill_word), 32'hFFFF_FFFF);
          end else begin
            wr = exp_wr_q.pop_front();
            check("fill_word", 32'(fill_word), 32'(wr.idx));
            check("fill_data", 32'(memory_data), 32'(wr.data));
            words_seen++;
            if (wr.idx == 3'd7) done_due = cyc + 1;
          end
        end
        if (exp_done && lat_chk) check("fill_latency", 32'(cyc - accept_cyc), 32'd13);
        if (exp_done) begin
          in_fill_m = 1'b0;
        end else if (!in_fill_m && miss_detected) begin
          base = miss_address & 16'hFFF0;
          for (int i = 0; i < 8; i++) begin
            exp_req_q.push_back('{base + 16'(2 * i), cyc + 1 + i});
            exp_wr_q.push_back('{3'(i), mem_word(base + 16'(2 * i))});
          end
          in_fill_m  = 1'b1;
          accept_cyc = cyc;
          words_seen = 0;
        end
      end
    end
  end

  // Present a miss for one cycle; called right after a rising edge.
  task automatic issue_miss(input logic [15:0] a);
    #1;
    miss_detected = 1'b1;
    miss_address  = a;
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      if (!in_fill_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit ok;
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);

    // Directed fill, fixed latency, unaligned address.
    lat_chk = 1'b1;
    issue_miss(16'h1236);
    wait_idle(200);
    lat_chk = 1'b0;

    // Gapped returns.
    gap_mode  = 1;
    extra_max = 2;
    issue_miss(16'($urandom));
    wait_idle(300);

    // Top-of-memory block, plus a miss presented during FILL that must be ignored.
    gap_mode  = 0;
    extra_max = 0;
    issue_miss(16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h0040;
    repeat (4) @(posedge clk);
    #1;
    miss_detected = 1'b0;
    wait_idle(200);

    // Reset part-way through a fill.
    @(posedge clk);
    issue_miss(16'h2468);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (words_seen >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_words_timeout", 32'd1, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(fsm_busy), 32'd0);
    check("async_rst_read_en", 32'(mem_read_en), 32'd0);
    check("async_rst_addr", 32'(memory_address), 32'd0);
    check("async_rst_write", 32'(write_data_array), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (ret_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd1, 32'd0);
    issue_miss(16'h2470);
    wait_idle(200);

    // Randomised fills, some back-to-back right after COMMIT.
    for (int n = 0; n < 20; n++) begin
      gap_mode  = int'($urandom_range(1, 0));
      extra_max = int'($urandom_range(3, 0));
      repeat ($urandom_range(2, 0)) @(posedge clk);
      issue_miss(16'($urandom));
      wait_idle(300);
    end

    repeat (10) @(posedge clk);
    check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
